// File: rtl/ili9341_pixel_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ili9341_pkg
//  Description : Shared definitions for the ILI9341 pixel feeder: command
//                opcodes, engine state encodings and the command FIFO entry
//                layout (2-bit op + 32-bit operand = 34 bits).
//  Revision    : 1.0 - initial release
// ============================================================================
package ili9341_pkg;

    // Command opcodes as presented on cmd_op.
    typedef enum logic [1:0] {
        OP_PIXEL  = 2'd0,
        OP_PIXEL2 = 2'd1,
        OP_FILL   = 2'd2,
        OP_CURSOR = 2'd3
    } op_e;

    // Replay engine states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_NEXT    = 3'd4
    } state_e;

    localparam int CMD_W = 34;

    typedef struct packed {
        op_e         op;
        logic [31:0] wdata;
    } cmd_t;

endpackage
`default_nettype wire

// File: rtl/ili9341_pixel_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : ili9341_pixel_feeder_if
//  Description : SoC-side command bus of the pixel feeder.
//                cmd_valid/cmd_ready : handshake, accept on valid && ready
//                cmd_op              : opcode (op_e)
//                cmd_wdata           : 32-bit operand
//                master = command producer, slave = pixel feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ili9341_pixel_feeder_if;
    import ili9341_pkg::*;

    logic        cmd_valid;
    logic        cmd_ready;
    op_e         cmd_op;
    logic [31:0] cmd_wdata;

    modport master (output cmd_valid, output cmd_op, output cmd_wdata, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_op, input  cmd_wdata, output cmd_ready);

endinterface
`default_nettype wire

// File: rtl/ili9341_pixel_feeder_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_cmd_fifo
//  Description : Single-clock first-word-fall-through command FIFO.
//                push_valid_i/push_data_i/push_ready_o : write side
//                pop_i/pop_data_o                       : read side (head)
//                level_o                                : occupied entries
//                push_ready_o and level_o are registered. Simultaneous
//                push and pop leave the level unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 34
) (
    input  wire logic                     clk_16MHz,
    input  wire logic                     resetn,
    input  wire logic                     push_valid_i,
    input  wire logic [WIDTH-1:0]         push_data_i,
    output logic                          push_ready_o,
    input  wire logic                     pop_i,
    output logic [WIDTH-1:0]              pop_data_o,
    output logic [$clog2(DEPTH):0]        level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ready_q, ready_d;
    logic             push, pop;

    always_comb begin
        push     = push_valid_i && ready_q;
        pop      = pop_i && (level_q != '0);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push) - LW'(pop);
        ready_d  = (level_d != LW'(DEPTH));
    end

    always_ff @(posedge clk_16MHz) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk_16MHz) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign pop_data_o   = mem_q[rd_ptr_q];
    assign push_ready_o = ready_q;
    assign level_o      = level_q;

endmodule
`default_nettype wire

// File: rtl/ili9341_pixel_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : ili9341_pixel_feeder
//  Description : Replays queued pixel/fill/cursor commands to the ILI9341
//                parallel driver, pacing on the driver's busy output.
//                clk_16MHz, resetn   : clock, synchronous active-low reset
//                cmd_bus (slave)     : command handshake, op, operand
//                busy_i              : driver not ready
//                pix_data_o          : RGB565 pixel (held through busy)
//                pix_clk_o           : one-cycle pixel strobe
//                reset_cursor_o      : one-cycle cursor-reset strobe
//                fifo_level_o        : queued commands
//                idle_o              : nothing queued, engine idle, busy low
//                Macro ILI9341_PIXEL_FEEDER_FILL_EN: when defined FILL repeats
//                wdata[31:16]+1 times; otherwise FILL sends one pixel.
//  Revision    : 1.0 - initial release
// ============================================================================
module ili9341_pixel_feeder
    import ili9341_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int GUARD_CYCLES = 1
) (
    input  wire logic                    clk_16MHz,
    input  wire logic                    resetn,
    ili9341_pixel_feeder_if.slave        cmd_bus,
    input  wire logic                    busy_i,
    output logic [15:0]                  pix_data_o,
    output logic                         pix_clk_o,
    output logic                         reset_cursor_o,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o,
    output logic                         idle_o
);
`ifdef ILI9341_PIXEL_FEEDER_FILL_EN
    localparam int CNT_W = 16;
`else
    localparam int CNT_W = 1;   // only PIXEL2 needs a second beat
`endif
    localparam int GUARD_W = (GUARD_CYCLES < 1) ? 1 : $clog2(GUARD_CYCLES + 1);

    logic [CMD_W-1:0]          fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic                      fifo_ready;
    logic                      fifo_empty;
    cmd_t                      head;

    state_e                    state_q;
    op_e                       op_q;
    logic [15:0]               pix_data_q;
    logic [15:0]               hi_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [GUARD_W-1:0]        guard_q;
    logic                      hi_wait_q;
    logic                      pix_clk_q;
    logic                      reset_cursor_q;
    logic                      idle_q;

    pixel_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk_16MHz    (clk_16MHz),
        .resetn       (resetn),
        .push_valid_i (cmd_bus.cmd_valid),
        .push_data_i  ({cmd_bus.cmd_op, cmd_bus.cmd_wdata}),
        .push_ready_o (fifo_ready),
        .pop_i        (state_q == ST_IDLE),
        .pop_data_o   (fifo_head),
        .level_o      (fifo_level)
    );

    assign head       = fifo_head;
    assign fifo_empty = (fifo_level == '0);

    always_ff @(posedge clk_16MHz) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            op_q           <= OP_PIXEL;
            pix_data_q     <= '0;
            hi_q           <= '0;
            cnt_q          <= '0;
            guard_q        <= '0;
            hi_wait_q      <= 1'b0;
            pix_clk_q      <= 1'b0;
            reset_cursor_q <= 1'b0;
            idle_q         <= 1'b0;
        end else begin
            pix_clk_q      <= 1'b0;
            reset_cursor_q <= 1'b0;
            idle_q         <= (state_q == ST_IDLE) && fifo_empty && !busy_i;

            // The guard free-runs down; the NEXT cycle itself is its first tick.
            if (guard_q != '0) begin
                guard_q <= guard_q - GUARD_W'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        op_q  <= head.op;
                        hi_q  <= head.wdata[31:16];
                        if (head.op != OP_CURSOR) begin
                            pix_data_q <= head.wdata[15:0];
                        end
                        case (head.op)
                            OP_PIXEL2: cnt_q <= CNT_W'(1);
`ifdef ILI9341_PIXEL_FEEDER_FILL_EN
                            OP_FILL:   cnt_q <= head.wdata[31:16];
`endif
                            default:   cnt_q <= '0;
                        endcase
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!busy_i && (guard_q == '0)) begin
                        if (op_q == OP_CURSOR) begin
                            reset_cursor_q <= 1'b1;
                        end else begin
                            pix_clk_q <= 1'b1;
                        end
                        hi_wait_q <= 1'b0;
                        state_q   <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    // Two cycles for busy to rise, else the strobe was lost.
                    if (busy_i) begin
                        state_q <= ST_WAIT_LO;
                    end else if (hi_wait_q) begin
                        state_q <= ST_ISSUE;
                    end else begin
                        hi_wait_q <= 1'b1;
                    end
                end
                ST_WAIT_LO: begin
                    if (!busy_i) begin
                        guard_q <= GUARD_W'(GUARD_CYCLES);
                        state_q <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (op_q == OP_PIXEL2) begin
                            pix_data_q <= hi_q;
                        end
                        state_q <= ST_ISSUE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_bus.cmd_ready = fifo_ready;
    assign pix_data_o        = pix_data_q;
    assign pix_clk_o         = pix_clk_q;
    assign reset_cursor_o    = reset_cursor_q;
    assign fifo_level_o      = fifo_level;
    assign idle_o            = idle_q;

endmodule
`default_nettype wire

// File: tb/tb_ili9341_pixel_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ili9341_pixel_feeder
//  Description : Self-checking bench for ili9341_pixel_feeder with a driver
//                model that raises busy for a fixed number of cycles per
//                accepted strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ili9341_pixel_feeder;
    import ili9341_pkg::*;

    localparam int FIFO_DEPTH   = 8;
    localparam int GUARD_CYCLES = 1;
    localparam int BUSY_PIX     = 3;
    localparam int BUSY_CUR     = 20;
    // Strobe t, busy t+1..t+BUSY_PIX, WAIT_LO sees low, NEXT (guard), ISSUE.
    localparam int PERIOD       = BUSY_PIX + 4;
    // Accept edge -> pop edge -> issue edge: strobe two counts after accept.
    localparam int LATENCY      = 2;

    logic        clk_16MHz = 1'b0;
    logic        resetn    = 1'b0;
    logic        hold_busy = 1'b0;
    logic        busy;
    logic [15:0] pix_data;
    logic        pix_clk, reset_cursor, idle;
    logic [3:0]  fifo_level;

    ili9341_pixel_feeder_if bus();

    ili9341_pixel_feeder #(.FIFO_DEPTH(FIFO_DEPTH), .GUARD_CYCLES(GUARD_CYCLES)) dut (
        .clk_16MHz      (clk_16MHz),
        .resetn         (resetn),
        .cmd_bus        (bus),
        .busy_i         (busy),
        .pix_data_o     (pix_data),
        .pix_clk_o      (pix_clk),
        .reset_cursor_o (reset_cursor),
        .fifo_level_o   (fifo_level),
        .idle_o         (idle)
    );

    always #31 clk_16MHz = ~clk_16MHz;

    int cyc = 0;
    always @(posedge clk_16MHz) cyc <= cyc + 1;

    // Driver model: registered busy response; drop_req strobes are ignored.
    int busy_cnt  = 0;
    int drop_req  = 0;
    int drop_done = 0;
    always @(posedge clk_16MHz) begin
        if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end else if (pix_clk || reset_cursor) begin
            if (drop_done < drop_req) drop_done <= drop_done + 1;
            else busy_cnt <= reset_cursor ? BUSY_CUR : BUSY_PIX;
        end
    end
    assign busy = (busy_cnt != 0) || hold_busy;

    // Monitor: records strobes and counts protocol violations.
    logic [15:0] stb_data[$];
    int          stb_cyc[$];
    int          cur_cyc[$];
    int          viol_both = 0, viol_consec = 0, viol_hold = 0;
    logic        prev_stb = 1'b0, hold_on = 1'b0, hold_hi = 1'b0;
    logic [15:0] hold_val = '0;
    always @(negedge clk_16MHz) begin
        if (!resetn) hold_on = 1'b0;
        if (pix_clk && reset_cursor) viol_both++;
        if ((pix_clk || reset_cursor) && prev_stb) viol_consec++;
        prev_stb = pix_clk || reset_cursor;
        if (pix_clk) begin
            stb_data.push_back(pix_data);
            stb_cyc.push_back(cyc);
            hold_on = 1'b1; hold_val = pix_data; hold_hi = 1'b0;
        end else if (hold_on) begin
            if (pix_data != hold_val) viol_hold++;
            if (busy) hold_hi = 1'b1;
            else if (hold_hi) hold_on = 1'b0;
        end
        if (reset_cursor) cur_cyc.push_back(cyc);
    end

    int chk_cnt  = 0;
    int pass_cnt = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    int accept_cyc = 0;
    task automatic send(input op_e op, input logic [31:0] wd);
        int n = 0;
        @(negedge clk_16MHz);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_wdata = wd;
        while (!bus.cmd_ready && n < 400) begin @(negedge clk_16MHz); n++; end
        if (n >= 400) check("send_timeout", 0, 1);
        @(negedge clk_16MHz);
        accept_cyc = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        repeat (2) @(negedge clk_16MHz);
        while (!idle && n < 2000) begin @(negedge clk_16MHz); n++; end
        if (n >= 2000) check(name, 0, 1);
        repeat (3) @(negedge clk_16MHz);
    endtask

    typedef struct {
        op_e         op;
        logic [31:0] wdata;
        int          exp_n;
        logic [15:0] exp_first;
        logic [15:0] exp_rest;
        int          exp_cur;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int base, cbase, n_at_reset;
        bus.cmd_valid = 1'b0; bus.cmd_op = OP_PIXEL; bus.cmd_wdata = '0;

        vecs[0] = '{OP_PIXEL,  32'h0000_F800, 1, 16'hF800, 16'h0000, 0};
        vecs[1] = '{OP_PIXEL2, 32'h07E0_001F, 2, 16'h001F, 16'h07E0, 0};
`ifdef ILI9341_PIXEL_FEEDER_FILL_EN
        vecs[2] = '{OP_FILL,   32'h0003_FFFF, 4, 16'hFFFF, 16'hFFFF, 0};
        vecs[4] = '{OP_FILL,   32'h0001_00AA, 2, 16'h00AA, 16'h00AA, 0};
`else
        vecs[2] = '{OP_FILL,   32'h0003_FFFF, 1, 16'hFFFF, 16'hFFFF, 0};
        vecs[4] = '{OP_FILL,   32'h0001_00AA, 1, 16'h00AA, 16'h00AA, 0};
`endif
        vecs[3] = '{OP_CURSOR, 32'h0000_0000, 0, 16'h0000, 16'h0000, 1};
        vecs[5] = '{OP_PIXEL,  32'hDEAD_1234, 1, 16'h1234, 16'h0000, 0};

        // Reset values, busy held high across release so idle stays low.
        hold_busy = 1'b1;
        repeat (4) @(negedge clk_16MHz);
        check("rst_pix_data", pix_data, 0);
        check("rst_pix_clk", pix_clk, 0);
        check("rst_reset_cursor", reset_cursor, 0);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_idle", idle, 0);
        resetn = 1'b1;
        repeat (3) @(negedge clk_16MHz);
        check("idle_while_busy", idle, 0);
        hold_busy = 1'b0;
        repeat (2) @(negedge clk_16MHz);
        check("idle_after_busy_low", idle, 1);

        // Table-driven single commands.
        foreach (vecs[v]) begin
            base  = stb_data.size();
            cbase = cur_cyc.size();
            send(vecs[v].op, vecs[v].wdata);
            wait_idle($sformatf("v%0d_idle_timeout", v));
            check($sformatf("v%0d_strobes", v), stb_data.size() - base, vecs[v].exp_n);
            check($sformatf("v%0d_cursors", v), cur_cyc.size() - cbase, vecs[v].exp_cur);
            if (vecs[v].exp_n > 0 && stb_data.size() > base) begin
                check($sformatf("v%0d_latency", v), stb_cyc[base] - accept_cyc, LATENCY);
                check($sformatf("v%0d_first", v), stb_data[base], vecs[v].exp_first);
                for (int i = base + 1; i < stb_data.size(); i++) begin
                    check($sformatf("v%0d_data%0d", v, i - base), stb_data[i], vecs[v].exp_rest);
                    check($sformatf("v%0d_gap%0d", v, i - base), stb_cyc[i] - stb_cyc[i-1], PERIOD);
                end
            end
            if (vecs[v].exp_cur > 0 && cur_cyc.size() > cbase)
                check($sformatf("v%0d_cur_latency", v), cur_cyc[cbase] - accept_cyc, LATENCY);
        end

        // Dropped strobe: driver ignores the first one, engine re-strobes.
        base = stb_data.size();
        drop_req = drop_req + 1;
        send(OP_PIXEL, 32'h0000_0BAD);
        wait_idle("drop_idle_timeout");
        check("drop_strobes", stb_data.size() - base, 2);
        if (stb_data.size() - base == 2) begin
            check("drop_gap", stb_cyc[base+1] - stb_cyc[base], 3);
            check("drop_data", stb_data[base+1], 16'h0BAD);
        end

        // CURSOR then PIXEL: pixel waits out the long cursor busy plus guard.
        base  = stb_data.size();
        cbase = cur_cyc.size();
        send(OP_CURSOR, 32'h0);
        send(OP_PIXEL, 32'h0000_1234);
        wait_idle("cur_pix_idle_timeout");
        check("cur_pix_cursors", cur_cyc.size() - cbase, 1);
        check("cur_pix_strobes", stb_data.size() - base, 1);
        if (cur_cyc.size() > cbase && stb_data.size() > base)
            check("cur_pix_delay", stb_cyc[base] - cur_cyc[cbase], BUSY_CUR + 5);

        // Fill the FIFO while busy is held: the engine holds one command,
        // the FIFO the other eight.
        base = stb_data.size();
        hold_busy = 1'b1;
        for (int i = 0; i < 9; i++) send(OP_PIXEL, 32'h0000_A000 + i);
        check("full_level", fifo_level, 8);
        check("full_ready", bus.cmd_ready, 0);
        @(negedge clk_16MHz);
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_PIXEL; bus.cmd_wdata = 32'h0000_BEEF;
        repeat (5) @(negedge clk_16MHz);
        bus.cmd_valid = 1'b0;
        check("full_refuse_level", fifo_level, 8);
        check("full_no_strobes", stb_data.size() - base, 0);
        hold_busy = 1'b0;
        wait_idle("drain_idle_timeout");
        check("drain_strobes", stb_data.size() - base, 9);
        for (int i = 0; i < 9; i++)
            if (base + i < stb_data.size())
                check($sformatf("drain_order%0d", i), stb_data[base+i], 16'hA000 + i);

        // Reset in the middle of a long run of pixels.
        base = stb_data.size();
`ifdef ILI9341_PIXEL_FEEDER_FILL_EN
        send(OP_FILL, 32'h0063_5A5A);
`else
        for (int i = 0; i < 6; i++) send(OP_PIXEL2, 32'h5A5A_5A5A);
`endif
        begin
            int n = 0;
            while (stb_data.size() - base < 10 && n < 1000) begin @(negedge clk_16MHz); n++; end
            if (n >= 1000) check("midrun_timeout", 0, 1);
        end
        n_at_reset = stb_data.size();
        resetn = 1'b0;
        @(negedge clk_16MHz);
        check("midrst_pix_clk", pix_clk, 0);
        check("midrst_level", fifo_level, 0);
        check("midrst_pix_data", pix_data, 0);
        @(negedge clk_16MHz);
        resetn = 1'b1;
        repeat (60) @(negedge clk_16MHz);
        check("midrst_no_strobes", stb_data.size(), n_at_reset);
        check("midrst_level_after", fifo_level, 0);
        send(OP_PIXEL, 32'h0000_00FF);
        wait_idle("postrst_idle_timeout");
        check("postrst_strobes", stb_data.size() - n_at_reset, 1);
        if (stb_data.size() > n_at_reset)
            check("postrst_data", stb_data[n_at_reset], 16'h00FF);

        check("viol_both", viol_both, 0);
        check("viol_consec", viol_consec, 0);
        check("viol_hold", viol_hold, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // Absolute backstop so the run always ends.
    initial begin
        #5000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
